// File: rtl/sti_pkg.sv
// Shared definitions for the STI serial link receiver.
//   LEN_*     : frame-length codes carried on cfg_length (8/16/24/32 bits)
//   state_t   : receiver FSM states
//   cfg_t     : frame configuration captured on the first bit of a frame
//   last_idx  : index of the last bit of a frame (N-1) for a length code
package sti_pkg;

   localparam logic [1:0] LEN_8  = 2'd0;
   localparam logic [1:0] LEN_16 = 2'd1;
   localparam logic [1:0] LEN_24 = 2'd2;
   localparam logic [1:0] LEN_32 = 2'd3;

   typedef enum logic {
      IDLE = 1'b0,
      RECV = 1'b1
   } state_t;

   typedef struct packed {
      logic [1:0] length;
      logic       msb;
      logic       fill;
      logic       low;
   } cfg_t;

   // N = 8*(length+1), so N-1 is the length code followed by three ones.
   function automatic logic [4:0] last_idx(input logic [1:0] length);
      return {length, 3'b111};
   endfunction

endpackage

// File: rtl/sti_rx_extract.sv
// Combinational word extraction for the STI receiver.
//   shreg   : received bits, oldest bit in shreg[N-1], newest in shreg[0]
//   cfg     : configuration of the frame being completed
//   data    : reconstructed 16-bit parallel word
//   pad_err : some padding bit of the frame word was 1 (0 when CHECK_PAD=0)
module sti_rx_extract
   import sti_pkg::*;
#(
   parameter bit CHECK_PAD = 1'b1
) (
   input  logic [31:0] shreg,
   input  cfg_t        cfg,
   output logic [15:0] data,
   output logic        pad_err
);

   logic [31:0] rev;
   logic [31:0] word;
   logic        pad;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case/if tree can leave a value unassigned and infer a latch.
      rev  = '0;
      word = '0;
      data = '0;
      pad  = 1'b0;

      for (int i = 0; i < 32; i++) begin
         rev[i] = shreg[31-i];
      end

      // MSB-first frames already sit in shreg as W. LSB-first frames are
      // mirrored inside the N-bit window; reversing all 32 bits puts that
      // window at the top, and shifting by 32-N brings it back to bit 0.
      if (cfg.msb) begin
         word = shreg;
      end else begin
         word = rev >> (5'd31 - last_idx(cfg.length));
      end

      case (cfg.length)
         LEN_8: begin
            data = cfg.low ? {8'h00, word[7:0]} : {word[7:0], 8'h00};
         end
         LEN_16: begin
            data = word[15:0];
         end
         LEN_24: begin
            data = cfg.fill ? word[23:8] : word[15:0];
            pad  = cfg.fill ? |word[7:0] : |word[23:16];
         end
         LEN_32: begin
            data = cfg.fill ? word[31:16] : word[15:0];
            pad  = cfg.fill ? |word[15:0] : |word[31:16];
         end
      endcase
   end

   assign pad_err = CHECK_PAD ? pad : 1'b0;

endmodule

// File: rtl/sti_rx.sv
// STI serial-to-parallel receiver.
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   si_data, si_valid   : serial bit and its strobe, one contiguous run per frame
//   cfg_length/msb/fill/low : frame format, captured on the first bit of a frame
//   po_data, po_valid   : reconstructed word and its one-cycle strobe
//   pad_err             : qualified by po_valid; a padding bit was 1
//   frame_err           : one-cycle pulse when a frame ended before N bits
//   rx_busy             : high while a frame is being received
module sti_rx
   import sti_pkg::*;
#(
   parameter bit CHECK_PAD = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        si_data,
   input  logic        si_valid,
   input  logic [1:0]  cfg_length,
   input  logic        cfg_msb,
   input  logic        cfg_fill,
   input  logic        cfg_low,
   output logic [15:0] po_data,
   output logic        po_valid,
   output logic        pad_err,
   output logic        frame_err,
   output logic        rx_busy
);

   state_t      state, state_nxt;
   logic [4:0]  bit_cnt, bit_cnt_nxt;
   logic [31:0] shreg, shreg_nxt;
   cfg_t        cfg_q, cfg_nxt;
   logic        done;
   logic        runt;
   logic [15:0] ext_data;
   logic        ext_pad;

   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      cfg_nxt     = cfg_q;
      done        = 1'b0;
      runt        = 1'b0;

      case (state)
         IDLE: begin
            if (si_valid) begin
               // First bit: clear stale bits so the frame starts in a clean register.
               shreg_nxt   = {31'b0, si_data};
               cfg_nxt     = cfg_t'{cfg_length, cfg_msb, cfg_fill, cfg_low};
               bit_cnt_nxt = 5'd1;
               state_nxt   = RECV;
            end
         end
         RECV: begin
            if (si_valid) begin
               shreg_nxt = {shreg[30:0], si_data};
               if (bit_cnt == last_idx(cfg_q.length)) begin
                  done        = 1'b1;
                  bit_cnt_nxt = 5'd0;
                  state_nxt   = IDLE;
               end else begin
                  bit_cnt_nxt = bit_cnt + 5'd1;
               end
            end else begin
               runt        = 1'b1;
               bit_cnt_nxt = 5'd0;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Extraction looks at the register as it will be after the current bit,
   // so the word is ready to register on the same edge that takes the last bit.
   sti_rx_extract #(
      .CHECK_PAD (CHECK_PAD)
   ) u_extract (
      .shreg   (shreg_nxt),
      .cfg     (cfg_q),
      .data    (ext_data),
      .pad_err (ext_pad)
   );

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the 32-bit shift register is ordinary flops, not a memory
         // array, so it is cleared with the rest of the state.
         state     <= IDLE;
         bit_cnt   <= '0;
         shreg     <= '0;
         cfg_q     <= '0;
         po_data   <= '0;
         po_valid  <= 1'b0;
         pad_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shreg     <= shreg_nxt;
         cfg_q     <= cfg_nxt;
         po_valid  <= done;
         pad_err   <= done & ext_pad;
         frame_err <= runt;
         if (done) begin
            po_data <= ext_data;
         end
      end
   end

   assign rx_busy = (state == RECV);

endmodule
